input_conditioner: RTL and testbench

//  Board-side front end between raw Nexys4 DDR pads (BTNC, SW[15:0]) and the sigma SoC inputs.
//  Per bit: synchronises to clk_i, debounces, and produces a clean level plus one-cycle rise/fall pulses.

---
 rtl/input_conditioner.sv | 101 ++++++++++
 tb/tb_input_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Pad input front end: per-bit synchroniser, counter debouncer, registered rise/fall
// pulses and a sticky, acknowledgeable interrupt raised by masked rising edges.
module input_conditioner #(
   parameter int               WIDTH       = 17,
   parameter int               SYNC_STAGES = 2,
   parameter int               DB_CYCLES   = 250000,
   parameter logic [WIDTH-1:0] RST_VAL     = '0,
   parameter logic [WIDTH-1:0] IRQ_MASK    = 17'h10000
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             irq_o,
   input  logic             irq_ack_i
);

   localparam int            CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_s;
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             irq_q, irq_d;
   logic             irq_set;

   // Only the first stage ever looks at raw_i.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= RST_VAL;
         end
      end else begin
         sync_q[0] <= raw_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      level_d = level_q;
      for (int b = 0; b < WIDTH; b++) begin
         cnt_d[b] = '0;
         if (sync_s[b] != level_q[b]) begin
            if (cnt_q[b] == CNT_LAST) begin
               level_d[b] = sync_s[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CW'(1);
            end
         end
      end
   end

   // Set has priority over ack so a rising edge coinciding with an ack is not lost.
   always_comb begin
      rise_d  = level_d & ~level_q;
      fall_d  = ~level_d & level_q;
      irq_set = |(rise_d & IRQ_MASK);
      irq_d   = irq_q;
      if (irq_set) begin
         irq_d = 1'b1;
      end else if (irq_ack_i) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int b = 0; b < WIDTH; b++) begin
            cnt_q[b] <= '0;
         end
         level_q <= RST_VAL;
         rise_q  <= '0;
         fall_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         for (int b = 0; b < WIDTH; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         irq_q   <= irq_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: window-based reference model with a per-cycle compare
// process, directed scenarios pinned by literal values, then randomized pad activity.
module tb_input_conditioner;

   localparam int             W    = 17;
   localparam int             SS   = 2;
   localparam int             DB   = 4;
   localparam logic [W-1:0]   RSTV = '0;
   localparam logic [W-1:0]   MASK = 17'h10000;
   localparam int             EW   = 3*W + 1;

   logic         clk;
   logic         arst_n_i;
   logic [W-1:0] raw_i;
   logic         irq_ack_i;
   logic [W-1:0] level_o, rise_o, fall_o;
   logic         irq_o;

   int n_cmp = 0;
   int n_err = 0;

   input_conditioner #(
      .WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB), .RST_VAL(RSTV), .IRQ_MASK(MASK)
   ) dut (
      .clk_i    (clk),
      .arst_n_i (arst_n_i),
      .raw_i    (raw_i),
      .level_o  (level_o),
      .rise_o   (rise_o),
      .fall_o   (fall_o),
      .irq_o    (irq_o),
      .irq_ack_i(irq_ack_i)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a level flips once the last DB synchronised samples all disagree with it.
   logic [W-1:0]  sync_m [$];
   logic [W-1:0]  s_hist [$];
   logic [EW-1:0] exp_q  [$];
   logic [W-1:0]  m_level, m_s, m_nl, m_rise, m_fall;
   logic          m_irq, m_all;

   always @(posedge clk) begin
      if (!arst_n_i) begin
         sync_m.delete();
         for (int i = 0; i < SS; i++) sync_m.push_back(RSTV);
         s_hist.delete();
         exp_q.delete();
         m_level = RSTV;
         m_irq   = 1'b0;
      end else begin
         m_s = sync_m.pop_front();
         sync_m.push_back(raw_i);
         s_hist.push_back(m_s);
         if (s_hist.size() > DB) void'(s_hist.pop_front());
         m_nl = m_level;
         if (s_hist.size() == DB) begin
            for (int b = 0; b < W; b++) begin
               m_all = 1'b1;
               for (int j = 0; j < s_hist.size(); j++) begin
                  if (s_hist[j][b] == m_level[b]) m_all = 1'b0;
               end
               if (m_all) m_nl[b] = ~m_level[b];
            end
         end
         m_rise = m_nl & ~m_level;
         m_fall = ~m_nl & m_level;
         if (|(m_rise & MASK)) m_irq = 1'b1;
         else if (irq_ack_i)   m_irq = 1'b0;
         m_level = m_nl;
         exp_q.push_back({m_irq, m_fall, m_rise, m_level});
      end
   end

   // scoreboard compare, 3 time units after each active edge
   logic [EW-1:0] e;
   always @(posedge clk) begin
      #3;
      if (!arst_n_i) begin
         check("rst_level", level_o, RSTV);
         check("rst_rise", rise_o, '0);
         check("rst_fall", fall_o, '0);
         check("rst_irq", W'(irq_o), '0);
      end else if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_empty: got no expectation expected one at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         check("level", level_o, e[W-1:0]);
         check("rise", rise_o, e[2*W-1:W]);
         check("fall", fall_o, e[3*W-1:2*W]);
         check("irq", W'(irq_o), W'(e[3*W]));
      end
   end

   // driver tasks: inputs change only on negedges
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic to_edge(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   logic [W-1:0] rmask;
   int           hold;

   initial begin
      arst_n_i  = 1'b0;
      raw_i     = 17'h1FFFF;
      irq_ack_i = 1'b0;
      to_edge(4);
      check("t1_level", level_o, 17'h0);
      check("t1_irq", W'(irq_o), 17'h0);
      @(negedge clk);
      raw_i = '0;
      @(negedge clk);
      arst_n_i = 1'b1;
      idle(8);

      // single switch rises
      raw_i = 17'h00008;
      to_edge(5);
      check("t2_level_e4", level_o, 17'h0);
      check("t2_rise_e4", rise_o, 17'h0);
      to_edge(1);
      check("t2_level_e5", level_o, 17'h00008);
      check("t2_rise_e5", rise_o, 17'h00008);
      check("t2_irq_e5", W'(irq_o), 17'h0);
      to_edge(1);
      check("t2_rise_e6", rise_o, 17'h0);
      @(negedge clk);
      idle(4);

      // glitches of 1 and 3 cycles, then an accepted hold
      raw_i = 17'h0;
      idle(1);
      raw_i = 17'h00008;
      idle(10);
      check("t3_glitch1", level_o, 17'h00008);
      raw_i = 17'h0;
      idle(3);
      raw_i = 17'h00008;
      idle(10);
      check("t3_glitch3", level_o, 17'h00008);
      raw_i = 17'h0;
      idle(6);
      check("t3_accept", level_o, 17'h0);
      idle(4);

      // button raises irq, ack clears it, release gives fall without irq
      raw_i = 17'h10000;
      to_edge(5);
      check("t4_irq_e4", W'(irq_o), 17'h0);
      to_edge(1);
      check("t4_rise", rise_o, 17'h10000);
      check("t4_irq_set", W'(irq_o), 17'h1);
      @(negedge clk);
      irq_ack_i = 1'b1;
      @(negedge clk);
      irq_ack_i = 1'b0;
      check("t4_irq_ack", W'(irq_o), 17'h0);
      idle(2);
      raw_i = 17'h0;
      to_edge(6);
      check("t4_fall", fall_o, 17'h10000);
      check("t4_irq_fall", W'(irq_o), 17'h0);
      @(negedge clk);
      idle(4);

      // ack held across the setting edge: set wins, next ack clears
      raw_i     = 17'h10000;
      irq_ack_i = 1'b1;
      to_edge(6);
      check("t5_set_wins", W'(irq_o), 17'h1);
      to_edge(1);
      check("t5_ack_next", W'(irq_o), 17'h0);
      @(negedge clk);
      irq_ack_i = 1'b0;
      raw_i     = 17'h0;
      idle(10);

      // reset in the middle of a pending change
      raw_i = 17'h00020;
      to_edge(4);
      @(negedge clk);
      arst_n_i = 1'b0;
      #1;
      check("t6_abort_level", level_o, 17'h0);
      check("t6_abort_rise", rise_o, 17'h0);
      idle(3);
      arst_n_i = 1'b1;
      to_edge(5);
      check("t6_level_e4", level_o, 17'h0);
      to_edge(1);
      check("t6_level_e5", level_o, 17'h00020);
      check("t6_rise_e5", rise_o, 17'h00020);
      @(negedge clk);
      idle(4);

      // randomized pad activity with occasional resets and acks
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 59) == 0) begin
            arst_n_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            arst_n_i = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) begin
            raw_i = W'($urandom);
         end else begin
            rmask = '0;
            rmask[$urandom_range(0, W-1)] = 1'b1;
            raw_i = raw_i ^ rmask;
         end
         hold = $urandom_range(1, 8);
         for (int c = 0; c < hold; c++) begin
            irq_ack_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
      end
      irq_ack_i = 1'b0;
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
